// File: rtl/alu_result_drain.sv
// rtl/alu_result_drain.sv - single-entry buffer that drains a wide ALU result vector as narrow beats
module alu_result_drain #(
    parameter  int DATA_W = 256,
    parameter  int OUT_W  = 32,
    localparam int BEATS  = DATA_W / OUT_W,
    localparam int IDX_W  = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [1:0]        in_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_last,
    output logic [1:0]        out_mode,
    output logic              busy
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

    typedef enum logic {
        S_IDLE,
        S_SEND
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   buf_q, buf_d;
    logic [1:0]          mode_q, mode_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                in_fire;
    logic                out_fire;

    always_comb begin
        state_d   = state_q;
        buf_d     = buf_q;
        mode_d    = mode_q;
        idx_d     = idx_q;
        out_valid = (state_q == S_SEND);
        out_last  = out_valid && (idx_q == LAST_IDX);
        // A consumed last beat frees the buffer in the same cycle.
        in_ready  = (state_q == S_IDLE) || (out_last && out_ready);
        in_fire   = in_valid && in_ready;
        out_fire  = out_valid && out_ready;

        if (in_fire) begin
            buf_d   = in_data;
            mode_d  = in_mode;
            idx_d   = '0;
            state_d = S_SEND;
        end else if (out_fire) begin
            if (out_last) begin
                idx_d   = '0;
                state_d = S_IDLE;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            buf_q   <= '0;
            mode_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            mode_q  <= mode_d;
            idx_q   <= idx_d;
        end
    end

    assign out_data = buf_q[idx_q*OUT_W +: OUT_W];
    assign out_idx  = idx_q;
    assign out_mode = mode_q;
    assign busy     = (state_q == S_SEND);

endmodule

// File: tb/tb_alu_result_drain.sv
// tb/tb_alu_result_drain.sv - randomized and directed bench for alu_result_drain against a beat-queue model
module tb_alu_result_drain;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [255:0] in_data;
    logic [1:0]   in_mode;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_data;
    logic [2:0]   out_idx;
    logic         out_last;
    logic [1:0]   out_mode;
    logic         busy;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    typedef struct packed {
        logic [31:0] data;
        logic [2:0]  idx;
        logic        last;
        logic [1:0]  mode;
    } beat_t;

    beat_t exp_q[$];

    always #5 clk = ~clk;

    alu_result_drain dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .out_mode  (out_mode),
        .busy      (busy)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void push_vec(input logic [255:0] v, input logic [1:0] m);
        beat_t b;
        for (int k = 0; k < 8; k++) begin
            b.data = v[k*32 +: 32];
            b.idx  = 3'(k);
            b.last = (k == 7);
            b.mode = m;
            exp_q.push_back(b);
        end
    endfunction

    function automatic logic [255:0] rand_vec();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Model: a vector is a queue of eight beats; the block is free when at most the final beat remains and is being taken.
    always @(negedge clk) begin
        if (chk_en) begin
            bit    exp_v;
            bit    exp_rdy;
            beat_t h;
            exp_v   = (exp_q.size() != 0);
            exp_rdy = (exp_q.size() == 0) || (exp_q.size() == 1 && out_ready);
            chk("out_valid", out_valid, exp_v);
            chk("busy", busy, exp_v);
            chk("in_ready", in_ready, exp_rdy);
            if (exp_v) begin
                h = exp_q[0];
                chk("out_data", out_data, h.data);
                chk("out_idx", out_idx, h.idx);
                chk("out_last", out_last, h.last);
                chk("out_mode", out_mode, h.mode);
            end
            if (rst) begin
                exp_q.delete();
            end else begin
                if (exp_v && out_ready) void'(exp_q.pop_front());
                if (in_valid && exp_rdy) push_vec(in_data, in_mode);
            end
        end
    end

    initial begin
        logic [255:0] v0, v1, v2;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_mode   = 2'b00;
        out_ready = 1'b0;
        step();
        chk_en = 1'b1;
        step();
        rst = 1'b0;

        // Reset / idle values
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_out_idx", out_idx, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_mode", out_mode, 0);
        step();

        // Single vector, sink always ready
        v0 = {32{8'hA5}};
        v0[7:0] = 8'h01;
        in_data = v0; in_mode = 2'b11; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("single_valid", out_valid, 1);
            chk("single_idx", out_idx, k);
            chk("single_last", out_last, (k == 7));
            chk("single_mode", out_mode, 2'b11);
            if (k == 0) chk("single_beat0", out_data, 32'hA5A5A501);
            if (k == 7) chk("single_beat7", out_data, 32'hA5A5A5A5);
            step();
        end
        @(negedge clk);
        chk("single_idle_valid", out_valid, 0);
        chk("single_idle_ready", in_ready, 1);

        // Backpressure: alternate stall / consume, 16 cycles
        step();
        v0 = rand_vec();
        in_data = v0; in_mode = 2'b01; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int c = 0; c < 16; c++) begin
            out_ready = c[0];
            @(negedge clk);
            chk("bp_idx", out_idx, c / 2);
            chk("bp_data", out_data, v0[(c/2)*32 +: 32]);
            step();
        end
        @(negedge clk);
        chk("bp_done", out_valid, 0);

        // Back-to-back: V1 accepted on V0's consumed last beat
        out_ready = 1'b1;
        v0 = rand_vec();
        v1 = rand_vec();
        in_data = v0; in_mode = 2'b00; in_valid = 1'b1;
        step();
        in_data = v1; in_mode = 2'b10;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            chk("b2b_valid", out_valid, 1);
            chk("b2b_idx", out_idx, c % 8);
            chk("b2b_data", out_data, (c < 8) ? v0[c*32 +: 32] : v1[(c-8)*32 +: 32]);
            chk("b2b_mode", out_mode, (c < 8) ? 2'b00 : 2'b10);
            if (c < 8) chk("b2b_in_ready", in_ready, (c == 7));
            step();
            if (c == 7) in_valid = 1'b0;
        end
        @(negedge clk);
        chk("b2b_done", out_valid, 0);

        // Reset at beat 3
        v0 = rand_vec();
        in_data = v0; in_mode = 2'b11; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step(); step(); step();
        @(negedge clk);
        chk("rst_mid_idx", out_idx, 3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_valid", out_valid, 0);
        chk("rst_mid_idx0", out_idx, 0);
        v2 = rand_vec();
        in_data = v2; in_mode = 2'b01; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("rst_new_idx", out_idx, 0);
        chk("rst_new_data", out_data, v2[31:0]);
        for (int k = 0; k < 8; k++) step();

        // Ignored input during beats 1..6
        v0 = rand_vec();
        in_data = v0; in_mode = 2'b10; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        for (int k = 1; k < 7; k++) begin
            in_valid = 1'b1;
            in_data = rand_vec();
            in_mode = 2'b01;
            @(negedge clk);
            chk("ign_in_ready", in_ready, 0);
            chk("ign_data", out_data, v0[k*32 +: 32]);
            step();
        end
        in_valid = 1'b0;
        step();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 2) != 0);
            in_data   = rand_vec();
            in_mode   = 2'($urandom_range(0, 3));
            out_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 1'b0;
        in_valid = 1'b0;
        step();
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
